// File: rtl/spsram_burst_master.sv
// Burst initiator for the single-port SRAM macro: turns one client command into
// a run of single-cycle SRAM accesses with wrapping addresses and a read-response stream.
module spsram_burst_master #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [AWIDTH-1:0] i_cmd_addr,
  input  logic [AWIDTH-1:0] i_cmd_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic              o_rdata_valid,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_rdata_last,
  output logic              o_busy,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0] o_mem_data,
  output logic              o_mem_wen,
  output logic              o_mem_cen,
  output logic              o_mem_oen,
  input  logic [DWIDTH-1:0] i_mem_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH-1:0] cnt_q;
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [RD_LAT-1:0] last_pipe_q;
  logic [RD_LAT-1:0] vld_pipe_d;
  logic [RD_LAT-1:0] last_pipe_d;
  logic              rd_issue;
  logic              cap_vld;
  logic              cap_last;

  assign rd_issue    = (state_q == READ);
  assign cap_vld     = vld_pipe_q[RD_LAT-1];
  assign cap_last    = last_pipe_q[RD_LAT-1];
  assign o_cmd_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);

  // Stage 0 is loaded on the issue edge; the top stage marks the capture edge.
  always_comb begin
    vld_pipe_d     = '0;
    last_pipe_d    = '0;
    vld_pipe_d[0]  = rd_issue;
    last_pipe_d[0] = rd_issue && (cnt_q == '0);
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  always_comb begin
    o_wdata_ready = 1'b0;
    o_mem_addr    = '0;
    o_mem_data    = '0;
    o_mem_wen     = 1'b0;
    o_mem_cen     = 1'b0;
    o_mem_oen     = 1'b0;
    case (state_q)
      WRITE: begin
        o_wdata_ready = 1'b1;
        o_mem_cen     = i_wdata_valid;
        o_mem_wen     = i_wdata_valid;
        o_mem_addr    = addr_q;
        o_mem_data    = i_wdata;
      end
      READ: begin
        o_mem_cen  = 1'b1;
        o_mem_oen  = 1'b1;
        o_mem_addr = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      vld_pipe_q    <= '0;
      last_pipe_q   <= '0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_rdata_last  <= 1'b0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      last_pipe_q   <= last_pipe_d;
      o_rdata_valid <= cap_vld;
      o_rdata_last  <= cap_vld && cap_last;
      if (cap_vld) begin
        o_rdata <= i_mem_data;
      end
      case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            addr_q  <= i_cmd_addr;
            cnt_q   <= i_cmd_len;
            state_q <= i_cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (i_wdata_valid) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= IDLE;
            end
          end
        end
        READ: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cap_vld && cap_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spsram_burst_master.sv
// Directed bench for spsram_burst_master with a behavioural SRAM of latency LAT.
module tb_spsram_burst_master;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_last, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, mem_rdata;
  logic          mem_wen, mem_cen, mem_oen;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spsram_burst_master #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(LAT)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
    .o_rdata_valid(rdata_valid), .o_rdata(rdata), .o_rdata_last(rdata_last),
    .o_busy(busy),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_wen(mem_wen),
    .o_mem_cen(mem_cen), .o_mem_oen(mem_oen), .i_mem_data(mem_rdata)
  );

  // SRAM model: data for a read issued on edge k appears after edge k+LAT-1.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_pipe [LAT];
  int            n_writes = 0;

  always @(posedge clk) begin
    if (mem_cen && mem_wen) begin
      mem[mem_addr] <= mem_data;
      n_writes      <= n_writes + 1;
    end
    if (mem_cen && mem_oen && !mem_wen) rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len,
                          input logic [DW-1:0] data[$], input bit pat[$]);
    int            beat = 0;
    int            cyc  = 0;
    int            w0;
    bit            v;
    logic [AW-1:0] ea;
    @(negedge clk);
    check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = addr; cmd_len = AW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    w0 = n_writes;
    while (beat <= len && cyc < 200) begin
      v = (cyc < pat.size()) ? pat[cyc] : 1'b1;
      wdata_valid = v;
      wdata       = data[beat];
      #1;
      check("wr_ready", {31'd0, wdata_ready}, 32'd1);
      check("wr_cen",   {31'd0, mem_cen},     {31'd0, v});
      check("wr_wen",   {31'd0, mem_wen},     {31'd0, v});
      check("wr_oen",   {31'd0, mem_oen},     32'd0);
      if (v) begin
        ea = AW'(32'(addr) + beat);
        check("wr_addr", {27'd0, mem_addr}, {27'd0, ea});
        check("wr_data", mem_data, data[beat]);
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    wdata_valid = 1'b0;
    check("wr_beats", beat, len + 1);
    check("wr_count", n_writes - w0, len + 1);
    check("wr_done_ready", {31'd0, cmd_ready}, 32'd1);
    check("wr_done_busy",  {31'd0, busy},      32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] exp[$]);
    int            got  = 0;
    bit            done = 1'b0;
    logic [AW-1:0] ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = addr; cmd_len = AW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < len + LAT + 10 && !done; c++) begin
      if (c <= len) begin
        ea = AW'(32'(addr) + c);
        check("rd_cen",  {31'd0, mem_cen},  32'd1);
        check("rd_oen",  {31'd0, mem_oen},  32'd1);
        check("rd_wen",  {31'd0, mem_wen},  32'd0);
        check("rd_addr", {27'd0, mem_addr}, {27'd0, ea});
      end else begin
        check("rd_drain_cen", {31'd0, mem_cen}, 32'd0);
      end
      if (c < len + 1 + LAT) check("rd_busy", {31'd0, busy}, 32'd1);
      if (rdata_valid) begin
        check("rd_time", c, LAT + 1 + got);
        check("rd_data", rdata, exp[got]);
        check("rd_last", {31'd0, rdata_last}, (got == len) ? 32'd1 : 32'd0);
        if (got == len) begin
          check("rd_done_ready", {31'd0, cmd_ready}, 32'd1);
          done = 1'b1;
        end
        got++;
      end
      if (!done) @(negedge clk);
    end
    check("rd_beats", got, len + 1);
  endtask

  initial begin
    logic [DW-1:0] d[$];
    logic [DW-1:0] e[$];
    bit            p[$];
    int            nv;

    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_wr = 1'($urandom);
      cmd_addr = AW'($urandom); cmd_len = AW'($urandom);
      wdata_valid = 1'($urandom); wdata = $urandom;
    end
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready},   32'd1);
    check("rst_busy",      {31'd0, busy},        32'd0);
    check("rst_rvalid",    {31'd0, rdata_valid}, 32'd0);
    check("rst_rlast",     {31'd0, rdata_last},  32'd0);
    check("rst_rdata",     rdata,                32'd0);
    check("rst_wready",    {31'd0, wdata_ready}, 32'd0);
    check("rst_mem_ctl",   {29'd0, mem_cen, mem_wen, mem_oen}, 32'd0);
    check("rst_mem_addr",  {27'd0, mem_addr},    32'd0);
    check("rst_mem_data",  mem_data,             32'd0);
    @(negedge clk);
    cmd_valid = 1'b0; wdata_valid = 1'b0;
    rstn = 1'b1;

    // write then read back
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    p = {};
    do_write(5'd2, 3, d, p);
    for (int i = 0; i < 4; i++) check("wr_mem_a0", mem[2+i], 32'hA0 + i);
    do_read(5'd2, 3, d);

    // wrap-around at top of memory
    d = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(5'd30, 3, d, p);
    check("wrap_mem30", mem[30], 32'd1);
    check("wrap_mem31", mem[31], 32'd2);
    check("wrap_mem0",  mem[0],  32'd3);
    check("wrap_mem1",  mem[1],  32'd4);
    do_read(5'd30, 3, d);

    // stalled write beats
    d = '{32'h11, 32'h22, 32'h33};
    p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_write(5'd10, 2, d, p);
    check("stall_mem10", mem[10], 32'h11);
    check("stall_mem12", mem[12], 32'h33);
    do_read(5'd10, 2, d);

    // full-depth burst starting mid-array
    d = {};
    p = {};
    for (int i = 0; i < 32; i++) d.push_back(32'((7 + i) % 32) ^ 32'h5A5A5A5A);
    do_write(5'd7, 31, d, p);
    check("full_mem0",  mem[0],  32'h5A5A5A5A);
    check("full_mem31", mem[31], 32'h5A5A5A45);
    do_read(5'd7, 31, d);

    // single-beat read
    e = '{32'h5A5A5A59};
    do_read(5'd3, 0, e);

    // reset two cycles into an 8-beat read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 5'd0; cmd_len = 5'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_cen",       {31'd0, mem_cen},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdata_valid) nv++;
    end
    check("midrst_no_valid", nv, 0);
    check("midrst_ready",    {31'd0, cmd_ready}, 32'd1);
    e = '{32'h5A5A5A5E, 32'h5A5A5A5F, 32'h5A5A5A5C};
    do_read(5'd4, 2, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spsram_burst_master.md
# spsram_burst_master

Burst-capable initiator that drives the single-port SRAM port (clock, data, address, write-enable, chip-enable, output-enable) on behalf of a client. It sits between a client with valid/ready command and write-data channels and the `spsram` macro. It converts one command into a run of single-cycle SRAM accesses with linear, wrapping addresses. Read data returns on a valid-only response stream with a last-beat flag.

## Interface
- `DWIDTH`, default 32: data width of SRAM and client data paths.
- `AWIDTH`, default 5: SRAM address width; depth = 2^AWIDTH.
- `RD_LAT`, default 1: SRAM read latency, in edges from issue edge to data on `i_mem_data`; legal range 1..4.

Ports (clock and reset first):
- `i_clk` input 1: single clock; all state changes on its rising edge.
- `i_rstn` input 1: reset, **asynchronous and active-low**.
- `i_cmd_valid` input 1: command valid.
- `o_cmd_ready` output 1: command accepted on an edge where valid and ready are both high.
- `i_cmd_wr` input 1: 1 = write burst, 0 = read burst.
- `i_cmd_addr` input AWIDTH: start address.
- `i_cmd_len` input AWIDTH: beats minus 1 (0 = 1 beat, 31 = 32 beats).
- `i_wdata_valid` input 1: write beat valid.
- `o_wdata_ready` output 1: write beat accepted when valid and ready are both high.
- `i_wdata` input DWIDTH: write beat data.
- `o_rdata_valid` output 1: read beat valid; no backpressure.
- `o_rdata` output DWIDTH: read beat data.
- `o_rdata_last` output 1: high with the final read beat of a burst.
- `o_busy` output 1: high whenever the FSM is not in IDLE.
- `o_mem_addr` output AWIDTH: SRAM address.
- `o_mem_data` output DWIDTH: SRAM write data.
- `o_mem_wen` output 1: SRAM write enable, active-high.
- `o_mem_cen` output 1: SRAM chip enable, active-high.
- `o_mem_oen` output 1: SRAM output enable, active-high.
- `i_mem_data` input DWIDTH: SRAM read data.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- `o_cmd_ready` = (state == IDLE). It is combinational and therefore 1 while reset is held.
- IDLE:
  - On command accept, latch address into `addr_q` and length into `cnt_q`.
  - Go to WRITE if `i_cmd_wr`=1, otherwise go to READ.
- WRITE:
  - `o_wdata_ready`=1.
  - Memory port is driven combinationally: `o_mem_cen` = `o_mem_wen` = `i_wdata_valid`, `o_mem_oen`=0, `o_mem_addr`=`addr_q`, `o_mem_data`=`i_wdata`.
  - Each accepted beat increments `addr_q` mod 2^AWIDTH and decrements `cnt_q`.
  - The beat accepted with `cnt_q`==0 is the last; go to IDLE.
  - Gaps in `i_wdata_valid` stall the burst and drive no SRAM access (`o_mem_cen`=0).
- READ:
  - Every cycle: `o_mem_cen`=1, `o_mem_oen`=1, `o_mem_wen`=0, `o_mem_addr`=`addr_q`. One issue per edge.
  - Each issue increments `addr_q` and decrements `cnt_q`. On the issue with `cnt_q`==0, go to DRAIN.
  - A RD_LAT-deep valid/last shift pipeline tracks issued beats.
- DRAIN:
  - No SRAM access (`o_mem_cen`=0).
  - Go to IDLE on the edge that captures the last beat.
- Read capture:
  - A beat issued at edge E(k) is sampled from `i_mem_data` into `o_rdata` at edge E(k+RD_LAT).
  - `o_rdata_valid` is asserted for exactly one cycle per beat.
  - `o_rdata_last` is asserted with the beat issued at `cnt_q`==0.
- Outside the states above, all `o_mem_*` signals are 0. `o_wdata_ready`=0 outside WRITE.
- Address arithmetic is modulo 2^AWIDTH: address 31 + 1 wraps to 0, and a 32-beat burst covers every word exactly once.
- Read commands are accepted only in IDLE, so a new command never overlaps the drain of the previous read.

## Timing
- Reset (`i_rstn` low, asynchronous):
  - State returns to IDLE; `addr_q`, `cnt_q` and the pipeline clear.
  - `o_rdata`=0, `o_rdata_valid`=0, `o_rdata_last`=0, `o_busy`=0, all `o_mem_*`=0, `o_wdata_ready`=0, `o_cmd_ready`=1.
  - Reset mid-burst abandons the burst and drops in-flight read beats. No partial response is emitted after release.
- Write latency: the first SRAM write can occur in the cycle after command accept. After the last write beat, `o_cmd_ready` is high in the next cycle.
- Read latency:
  - Command accepted at E0; first issue at E1; first `o_rdata_valid` is visible after edge E(1+RD_LAT).
  - An N-beat read occupies the FSM for N+RD_LAT cycles after accept.
  - `o_cmd_ready` is high in the cycle after `o_rdata_last` is captured.
- Read throughput: 1 beat per cycle. Write throughput: 1 beat per cycle when `i_wdata_valid` is held high.

## Test plan
- Reset: hold `i_rstn`=0 for 3 cycles with random inputs -> all outputs at reset values listed above, `o_cmd_ready`=1.
- Write then read: write addr 2, len 3, data 0xA0..0xA3, then read the same range -> SRAM holds 0xA0..0xA3 at 2..5; reads return 0xA0..0xA3 on 4 consecutive cycles, `o_rdata_last` on 0xA3, first valid RD_LAT+1 edges after accept.
- Wrap-around: write addr 30, len 3, data 1..4 -> SRAM addresses 30, 31, 0, 1. A read at addr 30, len 3 returns 1, 2, 3, 4.
- Stalled write: `i_wdata_valid` pattern 1,0,0,1,1 for a 3-beat burst -> exactly 3 SRAM writes, `o_mem_cen`=0 in the gap cycles, IDLE one cycle after the third beat.
- Full-depth and single-beat bursts:
  - Write all 32 words with len 31 and data = address XOR 0x5A5A5A5A, then read back -> all 32 match.
  - A len 0 read returns one beat with `o_rdata_valid` and `o_rdata_last` both high.
- Reset mid-read: assert `i_rstn` low two cycles into an 8-beat read -> `o_rdata_valid` stays 0 after release, `o_cmd_ready`=1, and the next command executes normally.
